panda_data_mem: RTL and testbench

Single-port data-memory responder: the far end of the Panda LSU data bus. It accepts load/store requests over a req/gnt/rvalid handshake and applies byte-enabled writes to an internal word array. It returns read data after a fixed, parameterised latency. It sits outside the core, next to the instruction memory, and serves as the bench and FPGA data store for the MEM stage.

---
 rtl/panda_data_mem.sv | 122 ++++++++++++
 tb/tb_panda_data_mem.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_data_mem.sv
// panda_data_mem: single-port data memory at the far end of the Panda LSU bus.
// Define PANDA_DMEM_ERR_EN to flag out-of-range accesses instead of wrapping them.
module panda_data_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          rvalid_reg, rvalid_next;
  logic          err_reg, err_next;
  logic          zero_reg, zero_next;
  logic          pend_zero_reg, pend_err_reg;
  logic [31:0]   hold_reg;
  logic [31:0]   rdata_reg;
  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic [3:0]    lane_we;
  logic          oor;
  logic          resp_now;
  logic          grant;
  logic          addr_unused;

  assign idx         = data_addr_i[AW+1:2];
  assign addr_unused = ^{data_addr_i[1:0], data_addr_i[31:AW+2]};

`ifdef PANDA_DMEM_ERR_EN
  assign oor = (data_addr_i >> (AW + 2)) != 32'd0;
`else
  assign oor = 1'b0;
`endif

  // The response cycle doubles as an accept slot so LATENCY=1 sustains one op per cycle.
  assign resp_now   = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign grant      = data_req_i && !rst_i && ((state_reg == IDLE) || resp_now);
  assign data_gnt_o = grant;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi] = grant && data_we_i && data_be_i[gi] && !oor;
  end

  // Array is never reset; stores commit and loads sample at the grant edge.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
    end
    if (grant && !data_we_i) hold_reg <= mem[idx];
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rvalid_next = 1'b0;
    err_next    = err_reg;
    zero_next   = zero_reg;
    if (grant) begin
      state_next = BUSY;
      cnt_next   = 4'(LATENCY - 1);
      if (LATENCY == 1) begin
        rvalid_next = 1'b1;
        err_next    = oor;
        zero_next   = data_we_i || oor;
      end
    end else if (state_reg == BUSY) begin
      if (resp_now) begin
        state_next = IDLE;
      end else begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          rvalid_next = 1'b1;
          err_next    = pend_err_reg;
          zero_next   = pend_zero_reg;
        end
      end
    end
    if (!rvalid_next) err_next = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      rvalid_reg    <= 1'b0;
      err_reg       <= 1'b0;
      zero_reg      <= 1'b1;
      rdata_reg     <= 32'd0;
      pend_zero_reg <= 1'b0;
      pend_err_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rvalid_reg <= rvalid_next;
      err_reg    <= err_next;
      zero_reg   <= zero_next;
      if (rvalid_next) rdata_reg <= hold_reg;
      if (grant) begin
        pend_zero_reg <= data_we_i || oor;
        pend_err_reg  <= oor;
      end
    end
  end

  // Store and error responses present zero data; otherwise the last load word is held.
  assign data_rdata_o  = zero_reg ? 32'd0 : ((LATENCY == 1) ? hold_reg : rdata_reg);
  assign data_rvalid_o = rvalid_reg;
  assign data_err_o    = err_reg;
endmodule

// File: tb/tb_panda_data_mem.sv
// Bench for panda_data_mem: three instances (LATENCY 1, 3, 4) checked against a
// transaction-level model; honours PANDA_DMEM_ERR_EN when defined.
module tb_panda_data_mem;
  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [ND];
  logic        we    [ND];
  logic [3:0]  be    [ND];
  logic [31:0] addr  [ND];
  logic [31:0] wdata [ND];
  logic        gnt   [ND];
  logic        rvalid[ND];
  logic        err   [ND];
  logic [31:0] rdata [ND];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  panda_data_mem #(.MEM_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_we_i(we[0]), .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
    .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));
  panda_data_mem #(.MEM_WORDS(1024), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_we_i(we[1]), .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
    .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));
  panda_data_mem #(.MEM_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
    .data_we_i(we[2]), .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
    .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  // Issue one request, drop req after its grant, and report the first response.
  task automatic txn(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic e,
                     output int lat_obs);
    int g;
    g = -1; lat_obs = -1; rd = 'x; e = 1'bx;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    for (int i = 0; i < 20 && g < 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (gnt[d] === 1'b1) g = i;
    end
    @(negedge clk);
    req[d] = 1'b0;
    if (g >= 0) begin
      for (int k = 1; k <= 20; k++) begin
        #1;
        if (rvalid[d] === 1'b1) begin
          rd = rdata[d]; e = err[d]; lat_obs = k;
          break;
        end
        @(negedge clk);
      end
    end
    $display("txn dut=%0d we=%0b be=%h addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             d, w, b, a, wd, rd, e, lat_obs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      req[d] = 1'b1; we[d] = 1'b0; be[d] = 4'hF; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        total++;
        if (gnt[d] !== 1'b0 || rvalid[d] !== 1'b0 || rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
          bad++;
          $display("FAIL reset dut=%0d cyc=%0d got gnt=%b rv=%b rdata=%h err=%b want all 0",
                   d, c, gnt[d], rvalid[d], rdata[d], err[d]);
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      total++;
      if (gnt[d] !== 1'b1) begin
        bad++;
        $display("FAIL reset_first_grant dut=%0d got=%b want=1", d, gnt[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) req[d] = 1'b0;
    repeat (6) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_partial_store();
    logic eg [5];
    logic ev [5];
    logic [31:0] erd [5];
    eg  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ev  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    erd = '{32'h0, 32'h0, 32'h0, 32'hAABB11DD, 32'hAABB11DD};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      case (k)
        0: begin req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'hAABBCCDD; end
        1: begin be[0] = 4'b0010; wdata[0] = 32'h00001100; end
        2: begin we[0] = 1'b0; be[0] = 4'h0; wdata[0] = 32'hFFFFFFFF; end
        default: req[0] = 1'b0;
      endcase
      #1;
      total++;
      if (gnt[0] !== eg[k] || rvalid[0] !== ev[k]) begin
        bad++;
        $display("FAIL partial_hs cyc=%0d got gnt=%b rv=%b want gnt=%b rv=%b", k, gnt[0], rvalid[0], eg[k], ev[k]);
      end
      if (k > 0) begin
        total++;
        if (rdata[0] !== erd[k] || (ev[k] && err[0] !== 1'b0)) begin
          bad++;
          $display("FAIL partial_data cyc=%0d got rdata=%h err=%b want rdata=%h err=0", k, rdata[0], err[0], erd[k]);
        end
      end
    end
    $display("test_partial_store done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int l;
    logic eg [7];
    logic ev [7];
    txn(1, 1'b1, 4'hF, 32'h40, 32'h11112222, rd, e, l);
    txn(1, 1'b1, 4'hF, 32'h44, 32'h33334444, rd, e, l);
    eg = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = 32'h40; end
      if (k == 1) addr[1] = 32'h44;
      if (k == 4) req[1] = 1'b0;
      #1;
      total++;
      if (gnt[1] !== eg[k] || rvalid[1] !== ev[k]) begin
        bad++;
        $display("FAIL b2b_hs T+%0d got gnt=%b rv=%b want gnt=%b rv=%b", k, gnt[1], rvalid[1], eg[k], ev[k]);
      end
      if (k == 3 || k == 6) begin
        total++;
        if (rdata[1] !== ((k == 3) ? 32'h11112222 : 32'h33334444)) begin
          bad++;
          $display("FAIL b2b_data T+%0d got=%h want=%h", k, rdata[1], (k == 3) ? 32'h11112222 : 32'h33334444);
        end
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int l;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'h12345678; end
      if (k == 1) req[2] = 1'b0;
      if (k == 2) rst = 1'b1;
      if (k == 3) rst = 1'b0;
      #1;
      total++;
      if (k == 0) begin
        if (gnt[2] !== 1'b1) begin
          bad++;
          $display("FAIL rstmid_grant got=%b want=1", gnt[2]);
        end
      end else if (rvalid[2] !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_rvalid T+%0d got=%b want=0", k, rvalid[2]);
      end
    end
    txn(2, 1'b0, 4'h0, 32'h20, 32'h0, rd, e, l);
    total++;
    if (rd !== 32'h12345678 || e !== 1'b0 || l != 4) begin
      bad++;
      $display("FAIL rstmid_load got rdata=%h err=%b lat=%0d want 12345678 0 4", rd, e, l);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_err();
    logic [31:0] rd; logic e; int l;
    logic        exp_err;
    logic [31:0] exp_w0;
`ifdef PANDA_DMEM_ERR_EN
    exp_err = 1'b1; exp_w0 = 32'hCAFEF00D;
`else
    exp_err = 1'b0; exp_w0 = 32'h5A5A5A5A;
`endif
    txn(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, rd, e, l);
    txn(0, 1'b1, 4'hF, 32'h1000, 32'h5A5A5A5A, rd, e, l);
    total++;
    if (rd !== 32'h0 || e !== exp_err || l != 1) begin
      bad++;
      $display("FAIL err_store got rdata=%h err=%b lat=%0d want 0 %b 1", rd, e, l, exp_err);
    end
    txn(0, 1'b0, 4'h0, 32'h0, 32'h0, rd, e, l);
    total++;
    if (rd !== exp_w0 || e !== 1'b0 || l != 1) begin
      bad++;
      $display("FAIL err_load0 got rdata=%h err=%b lat=%0d want %h 0 1", rd, e, l, exp_w0);
    end
    txn(1, 1'b0, 4'hF, 32'h1044, 32'h0, rd, e, l);
    total++;
    if (rd !== (exp_err ? 32'h0 : 32'h33334444) || e !== exp_err || l != 3) begin
      bad++;
      $display("FAIL err_load_oor got rdata=%h err=%b lat=%0d want err=%b", rd, e, l, exp_err);
    end
    $display("test_err done");
  endtask

  task automatic test_be0();
    logic [31:0] rd; logic e; int l;
    txn(1, 1'b1, 4'hF, 32'h4, 32'hDEADBEEF, rd, e, l);
    txn(1, 1'b1, 4'h0, 32'h4, 32'hFFFFFFFF, rd, e, l);
    total++;
    if (rd !== 32'h0 || e !== 1'b0 || l != 3) begin
      bad++;
      $display("FAIL be0_store got rdata=%h err=%b lat=%0d want 0 0 3", rd, e, l);
    end
    txn(1, 1'b0, 4'hF, 32'h4, 32'h0, rd, e, l);
    total++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      bad++;
      $display("FAIL be0_load got rdata=%h err=%b want DEADBEEF 0", rd, e);
    end
    $display("test_be0 done");
  endtask

  // Model: responses are due exactly LATENCY cycles after their grant; a request is
  // accepted when nothing is outstanding or the outstanding response is due now.
  task automatic test_random(input int d, input int n);
    logic [31:0] mm [64];
    logic [3:0]  kn [64];
    int          qdue[$];
    logic [31:0] qdat[$];
    logic pend, pw, eg, ev;
    logic [3:0]  pb;
    logic [31:0] pa, pd;
    int w, c;
    for (int i = 0; i < 64; i++) kn[i] = 4'h0;
    pend = 1'b0; pw = 1'b0; pb = 4'h0; pa = 32'h0; pd = 32'h0; w = 0; c = 0;
    while ((c < n || pend || qdue.size() > 0) && c < n + 100) begin
      @(negedge clk);
      if (!pend && c < n && $urandom_range(0, 3) != 0) begin
        w  = $urandom_range(0, 63);
        pw = (kn[w] != 4'hF) || ($urandom_range(0, 1) == 1);
        pb = 4'($urandom_range(0, 15));
        pa = (32'(w) << 2) | 32'($urandom_range(0, 3));
`ifndef PANDA_DMEM_ERR_EN
        pa = pa | (32'($urandom_range(0, 7)) << 12);
`endif
        pd = $urandom;
        pend = 1'b1;
      end
      req[d] = pend; we[d] = pw; be[d] = pb; addr[d] = pa; wdata[d] = pd;
      #1;
      ev = (qdue.size() > 0) && (qdue[0] == c);
      eg = pend && ((qdue.size() == 0) || ev);
      total++;
      if (gnt[d] !== eg || rvalid[d] !== ev) begin
        bad++;
        $display("FAIL rand_hs dut=%0d cyc=%0d got gnt=%b rv=%b want gnt=%b rv=%b", d, c, gnt[d], rvalid[d], eg, ev);
      end
      if (ev) begin
        total++;
        if (rdata[d] !== qdat[0] || err[d] !== 1'b0) begin
          bad++;
          $display("FAIL rand_data dut=%0d cyc=%0d got rdata=%h err=%b want %h 0", d, c, rdata[d], err[d], qdat[0]);
        end
        void'(qdue.pop_front());
        void'(qdat.pop_front());
      end
      if (pend && gnt[d] === 1'b1) begin
        if (pw) begin
          qdat.push_back(32'h0);
          for (int b = 0; b < 4; b++) if (pb[b]) mm[w][8*b +: 8] = pd[8*b +: 8];
          kn[w] = kn[w] | pb;
        end else begin
          qdat.push_back(mm[w]);
        end
        qdue.push_back(c + lat_of(d));
        pend = 1'b0;
      end
      c++;
    end
    req[d] = 1'b0;
    $display("test_random dut=%0d cycles=%0d done", d, c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_partial_store();
    test_back_to_back();
    test_reset_mid();
    test_err();
    test_be0();
    for (int d = 0; d < ND; d++) test_random(d, 300);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
